lzc_stream: RTL and testbench



---
 rtl/lzc_stream.sv | 162 ++++++++++++++++
 tb/tb_lzc_stream.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_stream.sv
// lzc_stream: per-frame zero counter over a stream of words.
// Mode 0 counts leading zeros of the frame read as one long number with
// the first word most significant. Mode 1 counts trailing zeros with the
// first word least significant. Each frame gives one result: the zero
// count, the number of words, an all-zero flag and a truncation flag.
//
// Handshake: a word transfers on a rising CLK edge where in_valid and
// in_ready are both 1. A result transfers on an edge where out_valid and
// out_ready are both 1. A valid signal is held, with its payload stable,
// until that transfer happens. in_ready does not depend on in_valid, and
// out_valid does not depend on out_ready.
module lzc_stream #(
  parameter int WIDTH    = 16,
  parameter int MAXWORDS = 8,
  localparam int ZW = $clog2(WIDTH * MAXWORDS + 1),
  localparam int NW = $clog2(MAXWORDS + 1)
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ZW-1:0]    out_zero,
  output logic [NW-1:0]    out_words,
  output logic             out_allzero,
  output logic             out_trunc
);

  // Width of a single-word zero count. It reaches WIDTH for a zero word.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [NW-1:0] LAST_WORD = NW'(MAXWORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic            mode_q;
  logic [ZW-1:0]   zcount;
  logic [NW-1:0]   words;
  logic            seen_nz;

  logic            accept;
  logic            eff_mode;
  logic [CW-1:0]   word_z;
  logic [ZW-1:0]   next_zcount;
  logic [NW-1:0]   next_words;
  logic            next_seen;
  logic            hit_max;
  logic            closes;

  function automatic logic [CW-1:0] lead_zeros(input logic [WIDTH-1:0] d);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (d[i]) found = 1'b1;
        else      n = n + CW'(1);
      end
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] trail_zeros(input logic [WIDTH-1:0] d);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found) begin
        if (d[i]) found = 1'b1;
        else      n = n + CW'(1);
      end
    end
    return n;
  endfunction

  // Per-word count and the frame values that would follow if this word
  // were accepted. The accumulators are already zero in IDLE, so the
  // same arithmetic starts a new frame. Only the mode has to come from
  // the port in IDLE, because the first word is the one that sets it.
  always_comb begin
    accept      = in_valid & in_ready;
    eff_mode    = (state == IDLE) ? in_mode : mode_q;
    word_z      = eff_mode ? trail_zeros(in_data) : lead_zeros(in_data);
    next_zcount = seen_nz ? zcount : zcount + ZW'(word_z);
    next_words  = words + NW'(1);
    next_seen   = seen_nz | (|in_data);
    hit_max     = (next_words == LAST_WORD);
    closes      = in_last | hit_max;
  end

  // Frame FSM. in_ready and the result outputs are registered here. The
  // result registers are loaded only when a frame closes and are cleared
  // when the result is consumed, so they read zero whenever out_valid=0.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      mode_q      <= 1'b0;
      zcount      <= '0;
      words       <= '0;
      seen_nz     <= 1'b0;
      out_valid   <= 1'b0;
      out_zero    <= '0;
      out_words   <= '0;
      out_allzero <= 1'b0;
      out_trunc   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          in_ready <= 1'b1;
          if (accept) begin
            mode_q  <= eff_mode;
            zcount  <= next_zcount;
            words   <= next_words;
            seen_nz <= next_seen;
            if (closes) begin
              state       <= DONE;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
              out_zero    <= next_zcount;
              out_words   <= next_words;
              out_allzero <= ~next_seen;
              out_trunc   <= hit_max & ~in_last;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            mode_q      <= 1'b0;
            zcount      <= '0;
            words       <= '0;
            seen_nz     <= 1'b0;
            out_valid   <= 1'b0;
            out_zero    <= '0;
            out_words   <= '0;
            out_allzero <= 1'b0;
            out_trunc   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_stream.sv
// Bench for lzc_stream at WIDTH=16, MAXWORDS=8: directed frames, hold,
// truncation, reset cases and randomized frames against a reference model.
module tb_lzc_stream;
  localparam int WIDTH    = 16;
  localparam int MAXWORDS = 8;
  localparam int ZW       = 8;
  localparam int NW       = 4;
  localparam int RW       = ZW + NW + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ZW-1:0]    out_zero;
  logic [NW-1:0]    out_words;
  logic             out_allzero;
  logic             out_trunc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW-1:0]    exp_q[$];
  logic [WIDTH-1:0] frame_q[$];

  wire [RW-1:0] res = {out_zero, out_words, out_allzero, out_trunc};

  lzc_stream #(.WIDTH(WIDTH), .MAXWORDS(MAXWORDS)) dut (
    .CLK(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_zero(out_zero), .out_words(out_words),
    .out_allzero(out_allzero), .out_trunc(out_trunc)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: read the frame as one long bit string in the chosen order
  // and count zeros up to the first one.
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] w[$],
                                          input bit mode, input bit trunc);
    int z   = 0;
    bit hit = 0;
    foreach (w[k]) begin
      for (int j = 0; j < WIDTH; j++) begin
        int b = mode ? j : WIDTH - 1 - j;
        if (!hit) begin
          if (w[k][b]) hit = 1;
          else         z++;
        end
      end
    end
    return {ZW'(z), NW'(w.size()), ~hit, trunc};
  endfunction

  // Driver: present one word at a negedge and hold it until accepted.
  // Returns at the negedge after the accepting edge with in_valid low.
  task automatic send_word(input logic [WIDTH-1:0] d, input bit last, input bit mode);
    int waitc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_mode  = mode;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waitc);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    in_last  = 1'($urandom);
    in_mode  = 1'($urandom);
  endtask

  // Driver: consume the pending result on the next edge.
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({in_ready, out_valid, res} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b res=%h, required all 0", in_ready, out_valid, res);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%0b before first edge, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_edge: rdy=%0b vld=%0b, required rdy=1 vld=0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_vectors();
    // Leading zeros across three words.
    send_word(16'h0000, 0, 0);
    send_word(16'h00F0, 0, 0);
    send_word(16'hFFFF, 1, 0);
    n_tests++;
    if (out_valid !== 1'b1 || res !== {8'd24, 4'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL vec_lz: vld=%0b z=%0d w=%0d a=%0b t=%0b, required vld=1 z=24 w=3 a=0 t=0",
               out_valid, out_zero, out_words, out_allzero, out_trunc);
    end
    consume();
    n_tests++;
    if (out_valid !== 1'b0 || res !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_after_consume: vld=%0b res=%h rdy=%0b, required vld=0 res=0 rdy=1",
               out_valid, res, in_ready);
    end
    // Trailing zeros; in_mode flips after the first word and must be ignored.
    send_word(16'h0000, 0, 1);
    send_word(16'h0F00, 0, 0);
    send_word(16'h0001, 1, 0);
    n_tests++;
    if (out_valid !== 1'b1 || res !== {8'd24, 4'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL vec_tz: vld=%0b z=%0d w=%0d a=%0b t=%0b, required vld=1 z=24 w=3 a=0 t=0",
               out_valid, out_zero, out_words, out_allzero, out_trunc);
    end
    consume();
    // All-zero frame of four words.
    for (int i = 0; i < 4; i++) send_word(16'h0000, i == 3, 0);
    n_tests++;
    if (out_valid !== 1'b1 || res !== {8'd64, 4'd4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL vec_allzero: vld=%0b z=%0d w=%0d a=%0b t=%0b, required vld=1 z=64 w=4 a=1 t=0",
               out_valid, out_zero, out_words, out_allzero, out_trunc);
    end
    consume();
  endtask

  task automatic test_trunc();
    for (int i = 0; i < MAXWORDS; i++) send_word(16'h0000, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1 || res !== {8'd128, 4'd8, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL trunc_result: vld=%0b z=%0d w=%0d a=%0b t=%0b, required vld=1 z=128 w=8 a=1 t=1",
               out_valid, out_zero, out_words, out_allzero, out_trunc);
    end
    // Ninth word waits while the result is pending.
    in_valid = 1'b1;
    in_data  = 16'h0000;
    in_last  = 1'b1;
    in_mode  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL trunc_hold_%0d: rdy=%0b vld=%0b, required rdy=0 vld=1", i, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== '0) begin
      n_fail++;
      $display("FAIL trunc_release: rdy=%0b vld=%0b res=%h, required rdy=1 vld=0 res=0", in_ready, out_valid, res);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || res !== {8'd16, 4'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL trunc_ninth: vld=%0b z=%0d w=%0d a=%0b t=%0b, required vld=1 z=16 w=1 a=1 t=0",
               out_valid, out_zero, out_words, out_allzero, out_trunc);
    end
    consume();
  endtask

  task automatic test_hold();
    send_word(16'h0100, 1, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = WIDTH'($urandom);
      in_last = 1'($urandom);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || res !== {8'd7, 4'd1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_%0d: vld=%0b rdy=%0b z=%0d w=%0d, required vld=1 rdy=0 z=7 w=1",
                 i, out_valid, in_ready, out_zero, out_words);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    consume();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_consumed: vld=%0b rdy=%0b, required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    send_word(16'h0000, 0, 0);
    send_word(16'h0000, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || res !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: rdy=%0b vld=%0b res=%h, required all 0", in_ready, out_valid, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_noresult: vld=%0b, required 0", out_valid);
      end
    end
    send_word(16'h8000, 1, 0);
    n_tests++;
    if (out_valid !== 1'b1 || res !== {8'd0, 4'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_next: vld=%0b z=%0d w=%0d a=%0b t=%0b, required vld=1 z=0 w=1 a=0 t=0",
               out_valid, out_zero, out_words, out_allzero, out_trunc);
    end
    // Reset while a result is pending drops it.
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || res !== '0) begin
      n_fail++;
      $display("FAIL reset_done: vld=%0b res=%h, required vld=0 res=0", out_valid, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int n     = $urandom_range(1, MAXWORDS);
      bit mode  = 1'($urandom);
      bit trunc = (n == MAXWORDS) && ($urandom_range(0, 1) == 1);
      frame_q.delete();
      for (int i = 0; i < n; i++) begin
        int r = $urandom_range(0, 5);
        logic [WIDTH-1:0] w;
        if (r < 3)       w = '0;
        else if (r == 3) w = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        else             w = WIDTH'($urandom);
        frame_q.push_back(w);
      end
      exp_q.push_back(model(frame_q, mode, trunc));
      for (int i = 0; i < n; i++) begin
        int gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        send_word(frame_q[i], (i == n - 1) && !trunc, (i == 0) ? mode : 1'($urandom));
      end
      n_tests++;
      if (out_valid !== 1'b1 || exp_q.size() == 0 || res !== exp_q[0]) begin
        n_fail++;
        $display("FAIL random_frame_%0d: vld=%0b res=%h, required vld=1 res=%h",
                 f, out_valid, res, (exp_q.size() != 0) ? exp_q[0] : '0);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_trunc();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
